// File: rtl/spi_slave_if.sv
// SPI slave front end for the RAM command block: 10-bit frames in on MOSI, one read byte out on MISO.
// Optional macro SPI_TX_TIMEOUT_EN abandons a read when tx_valid does not arrive within TIMEOUT_CYC cycles.
module spi_slave_if #(
    parameter int ADDR_SIZE   = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int FRAME_W = ADDR_SIZE + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TXC_W   = $clog2(ADDR_SIZE + 1);

    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(ADDR_SIZE - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_addr_seen_q, rd_addr_seen_d;
    logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 miso_q, miso_d;
    logic                 frame_done;

`ifdef SPI_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign frame_done = (bit_cnt_q == FRAME_LEN);

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        tx_busy_d      = tx_busy_q;
        tx_done_d      = tx_done_q;
        miso_d         = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
`endif
        // Deselect wins over everything, including a final-bit sample; rd_addr_seen survives for retry.
        if (ss_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            tx_busy_d = 1'b0;
            tx_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = CHK_CMD;
                    bit_cnt_d = '0;
                end
                CHK_CMD: begin
                    rx_shift_d = {{(FRAME_W-2){1'b0}}, mosi};
                    bit_cnt_d  = CNT_W'(1);
                    tx_cnt_d   = '0;
                    tx_busy_d  = 1'b0;
                    tx_done_d  = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                    if (!mosi) begin
                        state_d = WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!frame_done) begin
                        rx_shift_d = {rx_shift_q[FRAME_W-3:0], mosi};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d  = {rx_shift_q, mosi};
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD) begin
                                rd_addr_seen_d = 1'b1;
                            end
                        end
                    end else if (state_q == READ_DATA && !tx_done_q) begin
                        // Transmit phase: wait for tx_valid, then present MSB..LSB one per cycle.
                        if (tx_busy_q) begin
                            if (tx_cnt_q != '0) begin
                                miso_d     = tx_shift_q[ADDR_SIZE-1];
                                tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                                tx_cnt_d   = tx_cnt_q - TXC_W'(1);
                            end else begin
                                tx_busy_d      = 1'b0;
                                tx_done_d      = 1'b1;
                                rd_addr_seen_d = 1'b0;
                            end
                        end else if (tx_valid) begin
                            miso_d     = tx_data[ADDR_SIZE-1];
                            tx_shift_d = {tx_data[ADDR_SIZE-2:0], 1'b0};
                            tx_cnt_d   = TX_LAST;
                            tx_busy_d  = 1'b1;
`ifdef SPI_TX_TIMEOUT_EN
                        end else if (to_cnt_q == TO_LAST) begin
                            tx_done_d      = 1'b1;
                            rd_addr_seen_d = 1'b0;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
            miso_q         <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_busy_q      <= tx_busy_d;
            tx_done_q      <= tx_done_d;
            miso_q         <= miso_d;
`ifdef SPI_TX_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed table, hand sequences for reset/timeout, then random transactions
// checked against a transaction-level model (last received frame, read-address-seen flag).
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_vec = 0;
    int n_err = 0;

    logic       seen_m;
    logic [9:0] last_rx_m;

    spi_slave_if #(.ADDR_SIZE(8), .TIMEOUT_CYC(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        int         abort_at;   // 0: none; k: ss_n rises on the edge that samples frame bit k (1-based)
        int         tx_dly;
        logic [7:0] tx_byte;
        int         tx_abort;   // 0: none; m: ss_n rises instead of showing byte bit index 7-m
        logic       exp_valid;
        logic [9:0] exp_rx;
        logic       exp_shift;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic [9:0] frame, input int abort_at, input int tx_abort);
        if (abort_at == 0) begin
            last_rx_m = frame;
            if (frame[9]) begin
                if (seen_m) begin
                    if (tx_abort == 0) seen_m = 1'b0;
                end else begin
                    seen_m = 1'b1;
                end
            end
        end
    endtask

    task automatic run_txn(input vec_t v);
        bit aborted = 0;
        ss_n = 1'b0; mosi = 1'($urandom); tx_valid = 1'b0; tx_data = 8'($urandom);
        tick();
        chk("idle_miso", 32'(miso), 0);
        for (int i = 1; i <= 10; i++) begin
            mosi = v.frame[10-i];
            if (v.abort_at == i) ss_n = 1'b1;
            tick();
            chk("rx_miso", 32'(miso), 0);
            if (v.abort_at == i || i == 10) begin
                chk("rx_valid_end", 32'(rx_valid), 32'(v.exp_valid));
                chk("rx_data_end", 32'(rx_data), 32'(v.exp_rx));
            end else begin
                chk("rx_valid_mid", 32'(rx_valid), 0);
            end
            if (v.abort_at == i) begin
                aborted = 1;
                break;
            end
        end
        if (!aborted) begin
            if (v.exp_shift) begin
                for (int d = 0; d < v.tx_dly; d++) begin
                    tx_valid = 1'b0; tx_data = 8'($urandom);
                    tick();
                    chk("wait_miso", 32'(miso), 0);
                    chk("wait_rx_valid", 32'(rx_valid), 0);
                end
                tx_valid = 1'b1; tx_data = v.tx_byte;
                tick();
                chk("load_rx_valid", 32'(rx_valid), 0);
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) begin
                        tx_valid = 1'($urandom); tx_data = 8'($urandom);
                        if (v.tx_abort == k) ss_n = 1'b1;
                        tick();
                        if (v.tx_abort == k) begin
                            chk("tx_abort_miso", 32'(miso), 0);
                            aborted = 1;
                            break;
                        end
                    end
                    chk("tx_bit", 32'(miso), 32'(v.tx_byte[7-k]));
                end
                if (!aborted) begin
                    tx_valid = 1'b1; tx_data = 8'($urandom);
                    tick();
                    chk("tx_after", 32'(miso), 0);
                end
            end else begin
                for (int d = 0; d < 3; d++) begin
                    tx_valid = 1'b1; tx_data = 8'($urandom);
                    tick();
                    chk("noread_miso", 32'(miso), 0);
                    chk("noread_rx_valid", 32'(rx_valid), 0);
                end
            end
        end
        ss_n = 1'b1; tx_valid = 1'b0;
        tick();
        chk("end_miso", 32'(miso), 0);
        chk("end_rx_valid", 32'(rx_valid), 0);
        $display("txn frame=%03h abort_at=%0d tx_abort=%0d shift=%0d byte=%02h rx_data=%03h",
                 v.frame, v.abort_at, v.tx_abort, v.exp_shift, v.tx_byte, rx_data);
    endtask

    task automatic send_frame(input logic [9:0] frame);
        ss_n = 1'b0; tx_valid = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            mosi = frame[i];
            tick();
        end
        chk("hand_rx_valid", 32'(rx_valid), 1);
        chk("hand_rx_data", 32'(rx_data), 32'(frame));
    endtask

    function automatic vec_t mk(input logic [9:0] f, input int ab, input int dly, input logic [7:0] b,
                                input int tab, input logic ev, input logic [9:0] er, input logic es);
        vec_t v;
        v.frame = f; v.abort_at = ab; v.tx_dly = dly; v.tx_byte = b; v.tx_abort = tab;
        v.exp_valid = ev; v.exp_rx = er; v.exp_shift = es;
        return v;
    endfunction

    initial begin
        vec_t tbl [13];
        vec_t v;

        tbl[0]  = mk(10'h0A5, 0,  0, 8'h00, 0, 1'b1, 10'h0A5, 1'b0);
        tbl[1]  = mk(10'h203, 0,  0, 8'h00, 0, 1'b1, 10'h203, 1'b0);
        tbl[2]  = mk(10'h3FF, 0,  0, 8'hC3, 0, 1'b1, 10'h3FF, 1'b1);
        tbl[3]  = mk(10'h1FF, 6,  0, 8'h00, 0, 1'b0, 10'h3FF, 1'b0);
        tbl[4]  = mk(10'h155, 0,  0, 8'h00, 0, 1'b1, 10'h155, 1'b0);
        tbl[5]  = mk(10'h2AB, 0,  0, 8'h00, 0, 1'b1, 10'h2AB, 1'b0);
        tbl[6]  = mk(10'h2CC, 0,  2, 8'h5A, 0, 1'b1, 10'h2CC, 1'b1);
        tbl[7]  = mk(10'h3EE, 0,  0, 8'h00, 0, 1'b1, 10'h3EE, 1'b0);
        tbl[8]  = mk(10'h300, 0,  1, 8'hA5, 3, 1'b1, 10'h300, 1'b1);
        tbl[9]  = mk(10'h311, 0,  0, 8'h81, 0, 1'b1, 10'h311, 1'b1);
        tbl[10] = mk(10'h0F0, 10, 0, 8'h00, 0, 1'b0, 10'h311, 1'b0);
        tbl[11] = mk(10'h200, 1,  0, 8'h00, 0, 1'b0, 10'h311, 1'b0);
        tbl[12] = mk(10'h2FE, 0,  0, 8'h00, 0, 1'b1, 10'h2FE, 1'b0);

        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_miso", 32'(miso), 0);
        chk("reset_rx_valid", 32'(rx_valid), 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        seen_m = 1'b0; last_rx_m = 10'h000;

        for (int t = 0; t < 13; t++) begin
            run_txn(tbl[t]);
            model_update(tbl[t].frame, tbl[t].abort_at, tbl[t].tx_abort);
        end

        // Reset while bit 4 of the read byte is on MISO.
        send_frame(10'h3C0);
        tx_valid = 1'b1; tx_data = 8'hC3;
        tick();
        chk("rst_seq_b7", 32'(miso), 1);
        tx_valid = 1'b0;
        tick(); chk("rst_seq_b6", 32'(miso), 1);
        tick(); chk("rst_seq_b5", 32'(miso), 0);
        tick(); chk("rst_seq_b4", 32'(miso), 0);
        rst = 1'b1;
        tick();
        chk("rst_mid_miso", 32'(miso), 0);
        chk("rst_mid_rx_valid", 32'(rx_valid), 0);
        chk("rst_mid_rx_data", 32'(rx_data), 0);
        rst = 1'b0; ss_n = 1'b1;
        tick();
        $display("txn reset during read shift");
        seen_m = 1'b0; last_rx_m = 10'h000;
        v = mk(10'h300, 0, 0, 8'h77, 0, 1'b1, 10'h300, 1'b0);
        run_txn(v); model_update(v.frame, v.abort_at, v.tx_abort);
        v = mk(10'h3AA, 0, 0, 8'h96, 0, 1'b1, 10'h3AA, 1'b1);
        run_txn(v); model_update(v.frame, v.abort_at, v.tx_abort);

`ifdef SPI_TX_TIMEOUT_EN
        v = mk(10'h201, 0, 0, 8'h00, 0, 1'b1, 10'h201, 1'b0);
        run_txn(v); model_update(v.frame, v.abort_at, v.tx_abort);
        send_frame(10'h3D4);
        for (int c = 0; c < 80; c++) begin
            tx_valid = (c >= 70); tx_data = 8'hFF;
            tick();
            chk("timeout_miso", 32'(miso), 0);
        end
        ss_n = 1'b1; tx_valid = 1'b0;
        tick();
        $display("txn read-data timeout");
        seen_m = 1'b0; last_rx_m = 10'h3D4;
        v = mk(10'h3D5, 0, 0, 8'hFF, 0, 1'b1, 10'h3D5, 1'b0);
        run_txn(v); model_update(v.frame, v.abort_at, v.tx_abort);
`endif

        for (int r = 0; r < 150; r++) begin
            v.frame    = 10'($urandom);
            v.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            v.tx_abort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
            v.tx_dly   = int'($urandom_range(0, 4));
            v.tx_byte  = 8'($urandom);
            v.exp_valid = (v.abort_at == 0);
            v.exp_rx    = v.exp_valid ? v.frame : last_rx_m;
            v.exp_shift = v.exp_valid && v.frame[9] && seen_m;
            run_txn(v);
            model_update(v.frame, v.abort_at, v.tx_abort);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
